or16_serial: RTL and testbench
==============================

# or16_serial

Bit-serial counterpart of the combinational 16-bit bitwise OR. It accepts two 16-bit operands over a valid/ready handshake and computes `a | b` LANE bits per cycle, LSB-first. It streams each result slice out as it is produced and holds the assembled 16-bit word for the next stage. It sits between the parallel register file and narrow serial datapaths (bit-serial ALU lanes, I/O shifters) where a full 16-bit OR bank is not wanted.

## Interface
- `WIDTH`, 16: operand and result width; must be a multiple of `LANE`.
- `LANE`, 1: bits processed per cycle; legal values 1, 2, 4, 8, 16.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `slice_valid` output 1: `slice_out` carries a valid result slice this cycle.
- `slice_out` output LANE: current result slice, i.e. `(a|b)[k*LANE +: LANE]`.
- `out_valid` output 1: `out` holds a complete result.
- `out_ready` input 1: consumer accepts `out`.
- `out` output WIDTH: assembled result word.

## Operation
- State machine, three states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `a` and `b` into shift registers, clear the slice counter, and go to SHIFT.
  - SHIFT: each cycle, `slice_valid`=1 and `slice_out` = OR of the low LANE bits of both shift registers. Insert the slice into `out` at position k*LANE, shift both registers right by LANE, and increment k. After slice k = WIDTH/LANE−1, go to DONE.
  - DONE: `out_valid`=1 and `out` is held stable. On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; operands are never re-latched mid-operation.
- Slice counter width is clog2(WIDTH/LANE), minimum 1. It wraps to 0 on leaving SHIFT.
- When `LANE`=`WIDTH`, SHIFT lasts exactly one cycle.
- `out` bits not yet written during SHIFT read 0; `out` is cleared on acceptance.
- Asserting `rst_n` low mid-operation aborts at once: the state returns to IDLE and partial results are discarded.

## Timing
- Reset values: `in_ready`=1, `slice_valid`=0, `slice_out`=0, `out_valid`=0, `out`=0, state IDLE.
- Accept at edge T → first slice visible in cycle T+1 → last slice in cycle T+WIDTH/LANE.
- `out_valid` rises in cycle T+WIDTH/LANE+1.
- With LANE=1, accept-to-`out_valid` latency is 17 cycles.
- `out_valid`&&`out_ready` at edge D → IDLE, `in_ready`=1 in cycle D+1. The earliest next accept is edge D+1, so there is one bubble per operation and no overlap.
- `out_ready` held high early is harmless; it only takes effect in DONE.
- `slice_valid` and `slice_out` are registered outputs, so there is no combinational path from inputs.
- `in_ready` and `out_valid` are decoded from registered state only.

## Configuration
- `OR16_SERIAL_ZERO_FLAG_EN`
  - Defined: adds output `zr` (1 bit). It resets to 0, is cleared on accept, and is valid with `out_valid`. `zr`=1 iff every slice was 0. It is computed incrementally by ANDing per-slice NOR results, not by reducing `out`.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, `slice_valid`=0, `out`=0.
- LANE=1, `a`=16'h00F0, `b`=16'h0F01 → `slice_out` sequence LSB-first 1,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0 over cycles T+1..T+16; `out`=16'h0FF1 with `out_valid` at T+17.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → `out` stays 16'h0FF1, `in_ready`=0, and a new `in_valid` is ignored. Release → `in_ready`=1 the next cycle.
- LANE=4, `a`=16'hA5A5, `b`=16'h5A5A → four slices of 4'hF; `out`=16'hFFFF at T+5; `zr`=0 if enabled.
- Zero operands with `OR16_SERIAL_ZERO_FLAG_EN` defined: `a`=`b`=0 → `out`=0 and `zr`=1. A following op with `a`=16'h8000 → `zr`=0, with the set bit arriving in the last slice only.
- Reset mid-operation: drop `rst_n` at slice 7 → immediate IDLE with `out`=0. The next op with `a`=16'hFFFF, `b`=0 completes normally with `out`=16'hFFFF.

Source files
------------

// File: rtl/or16_serial_if.sv
// ---------------------------------------------------------------------------
// or16_serial_if
//   Bundles the operand handshake, the streamed result slices and the
//   assembled-result handshake of or16_serial.
//
//   Signals
//     in_valid / in_ready  : operand handshake (a, b accepted when both high)
//     a, b                 : WIDTH-bit operands
//     slice_valid          : slice_out carries a result slice this cycle
//     slice_out            : LANE-bit result slice, LSB-first
//     out_valid / out_ready: assembled-result handshake
//     out                  : WIDTH-bit assembled result
//     zr                   : all-slices-zero flag (only with
//                            OR16_SERIAL_ZERO_FLAG_EN defined)
//
//   Modports
//     slave  : the or16_serial block
//     master : the environment driving operands and consuming results
// ---------------------------------------------------------------------------
interface or16_serial_if #(
    parameter int WIDTH = 16,
    parameter int LANE  = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             slice_valid;
    logic [LANE-1:0]  slice_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
    logic             zr;
`endif

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, slice_valid, slice_out, out_valid, out
`ifdef OR16_SERIAL_ZERO_FLAG_EN
        , output zr
`endif
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, slice_valid, slice_out, out_valid, out
`ifdef OR16_SERIAL_ZERO_FLAG_EN
        , input zr
`endif
    );
endinterface

// File: rtl/or16_serial.sv
// ---------------------------------------------------------------------------
// or16_serial
//   Bit-serial bitwise OR: accepts two WIDTH-bit operands, produces
//   a|b LANE bits per cycle LSB-first, streams each slice on slice_out and
//   assembles the full word on out, held until the consumer accepts it.
//
//   Ports
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : or16_serial_if.slave (operand / slice / result signals)
//
//   Parameters
//     WIDTH : operand width, multiple of LANE
//     LANE  : bits per cycle (1, 2, 4, 8 or 16)
//
//   Configuration macro
//     OR16_SERIAL_ZERO_FLAG_EN : adds bus.zr, set when every slice was zero
// ---------------------------------------------------------------------------
module or16_serial #(
    parameter int WIDTH = 16,
    parameter int LANE  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    or16_serial_if.slave  bus
);
    localparam int NSLICE = WIDTH / LANE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_q;
    logic             slice_valid_q;
    logic [LANE-1:0]  slice_out_q;
    logic [LANE-1:0]  slice_d;
    logic [LANE-1:0]  first_slice_d;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
    logic             all_zero_q;
    logic             zr_q;
`endif

    // Next slice from the remaining operand bits, and the first slice taken
    // straight from the inputs so it is already registered in cycle T+1.
    assign slice_d       = a_q[LANE-1:0] | b_q[LANE-1:0];
    assign first_slice_d = bus.a[LANE-1:0] | bus.b[LANE-1:0];

    // The shift registers hold operands already shifted past the slice that
    // currently sits in slice_out_q; slice_out_q is written into out_q on the
    // edge that ends its cycle.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            out_q         <= '0;
            slice_valid_q <= 1'b0;
            slice_out_q   <= '0;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
            all_zero_q    <= 1'b0;
            zr_q          <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q           <= bus.a >> LANE;
                        b_q           <= bus.b >> LANE;
                        cnt_q         <= '0;
                        out_q         <= '0;
                        slice_valid_q <= 1'b1;
                        slice_out_q   <= first_slice_d;
                        state_q       <= SHIFT;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
                        all_zero_q    <= 1'b1;
                        zr_q          <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    out_q[cnt_q*LANE +: LANE] <= slice_out_q;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
                    // Running AND of per-slice NORs.
                    all_zero_q <= all_zero_q & ~(|slice_out_q);
`endif
                    if (cnt_q == LAST) begin
                        cnt_q         <= '0;
                        slice_valid_q <= 1'b0;
                        slice_out_q   <= '0;
                        state_q       <= DONE;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
                        zr_q          <= all_zero_q & ~(|slice_out_q);
`endif
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        slice_out_q <= slice_d;
                        a_q         <= a_q >> LANE;
                        b_q         <= b_q >> LANE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.slice_valid = slice_valid_q;
    assign bus.slice_out   = slice_out_q;
    assign bus.out         = out_q;
`ifdef OR16_SERIAL_ZERO_FLAG_EN
    assign bus.zr          = zr_q;
`endif

endmodule

// File: tb/tb_or16_serial.sv
// ---------------------------------------------------------------------------
// tb_or16_serial
//   Directed bench for or16_serial with two instances (LANE=1 and LANE=4)
//   sharing clock and reset. Inputs change 1 ns after the rising edge and
//   outputs are sampled at the same point, i.e. the value held in that cycle.
// ---------------------------------------------------------------------------
module tb_or16_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    or16_serial_if #(.WIDTH(16), .LANE(1)) if1 ();
    or16_serial_if #(.WIDTH(16), .LANE(4)) if4 ();

    or16_serial #(.WIDTH(16), .LANE(1)) u_lane1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    or16_serial #(.WIDTH(16), .LANE(4)) u_lane4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one LANE=1 operation from accept to the first DONE cycle,
    // checking every slice and the partially assembled word along the way.
    task automatic run1(input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_w, input string tag);
        logic [15:0] mask;
        if1.a        = av;
        if1.b        = bv;
        if1.in_valid = 1'b1;
        check({tag, ".in_ready_before"}, 32'(if1.in_ready), 32'd1);
        step();
        if1.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mask = (16'd1 << k) - 16'd1;
            check({tag, ".slice_valid"}, 32'(if1.slice_valid), 32'd1);
            check({tag, ".slice_out"},   32'(if1.slice_out),   32'(exp_w[k]));
            check({tag, ".partial_out"}, 32'(if1.out),         32'(exp_w & mask));
            check({tag, ".busy_in_ready"}, 32'(if1.in_ready),  32'd0);
            check({tag, ".early_out_valid"}, 32'(if1.out_valid), 32'd0);
            step();
        end
        check({tag, ".out_valid"},   32'(if1.out_valid),   32'd1);
        check({tag, ".out"},         32'(if1.out),         32'(exp_w));
        check({tag, ".slice_idle"},  32'(if1.slice_valid), 32'd0);
        check({tag, ".done_in_ready"}, 32'(if1.in_ready),  32'd0);
    endtask

    task automatic release1(input string tag);
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        check({tag, ".rel_in_ready"},  32'(if1.in_ready),  32'd1);
        check({tag, ".rel_out_valid"}, 32'(if1.out_valid), 32'd0);
        check({tag, ".rel_out"},       32'(if1.out),       32'd0);
    endtask

    initial begin
        // Reset with random inputs applied.
        rst_n         = 1'b0;
        if1.in_valid  = 1'($urandom);
        if1.a         = 16'($urandom);
        if1.b         = 16'($urandom);
        if1.out_ready = 1'($urandom);
        if4.in_valid  = 1'($urandom);
        if4.a         = 16'($urandom);
        if4.b         = 16'($urandom);
        if4.out_ready = 1'($urandom);
        repeat (3) step();
        check("rst.in_ready",    32'(if1.in_ready),    32'd1);
        check("rst.out_valid",   32'(if1.out_valid),   32'd0);
        check("rst.slice_valid", 32'(if1.slice_valid), 32'd0);
        check("rst.slice_out",   32'(if1.slice_out),   32'd0);
        check("rst.out",         32'(if1.out),         32'd0);
        check("rst4.in_ready",   32'(if4.in_ready),    32'd1);
        check("rst4.out",        32'(if4.out),         32'd0);
`ifdef OR16_SERIAL_ZERO_FLAG_EN
        check("rst.zr",          32'(if1.zr),          32'd0);
`endif
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b0;
        rst_n         = 1'b1;
        step();

        // LANE=1: 00F0 | 0F01 = 0FF1, slices 1,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0.
        run1(16'h00F0, 16'h0F01, 16'h0FF1, "op1");

        // Backpressure in DONE with a competing in_valid that must be ignored.
        for (int i = 0; i < 5; i++) begin
            if1.in_valid = 1'b1;
            if1.a        = 16'hFFFF;
            if1.b        = 16'hFFFF;
            check("bp.out",         32'(if1.out),         32'h0FF1);
            check("bp.out_valid",   32'(if1.out_valid),   32'd1);
            check("bp.in_ready",    32'(if1.in_ready),    32'd0);
            check("bp.slice_valid", 32'(if1.slice_valid), 32'd0);
            step();
        end
        if1.in_valid = 1'b0;
        release1("bp");

        // LANE=4 with out_ready held high from the start.
        if4.out_ready = 1'b1;
        if4.a         = 16'hA5A5;
        if4.b         = 16'h5A5A;
        if4.in_valid  = 1'b1;
        step();
        if4.in_valid  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("l4.slice_valid", 32'(if4.slice_valid), 32'd1);
            check("l4.slice_out",   32'(if4.slice_out),   32'hF);
            check("l4.partial_out", 32'(if4.out),         32'((16'd1 << (4 * k)) - 16'd1));
            check("l4.out_valid_early", 32'(if4.out_valid), 32'd0);
            step();
        end
        check("l4.out_valid", 32'(if4.out_valid), 32'd1);
        check("l4.out",       32'(if4.out),       32'hFFFF);
`ifdef OR16_SERIAL_ZERO_FLAG_EN
        check("l4.zr",        32'(if4.zr),        32'd0);
`endif
        step();
        check("l4.rel_in_ready", 32'(if4.in_ready), 32'd1);
        check("l4.rel_out",      32'(if4.out),      32'd0);
        if4.out_ready = 1'b0;

        // Zero operands, then a single set bit in the last slice.
        run1(16'h0000, 16'h0000, 16'h0000, "zero");
`ifdef OR16_SERIAL_ZERO_FLAG_EN
        check("zero.zr", 32'(if1.zr), 32'd1);
`endif
        release1("zero");
        run1(16'h8000, 16'h0000, 16'h8000, "msb");
`ifdef OR16_SERIAL_ZERO_FLAG_EN
        check("msb.zr", 32'(if1.zr), 32'd0);
`endif
        release1("msb");

        // Reset in the cycle carrying slice 7: 1234 | 0001 = 1235.
        if1.a        = 16'h1234;
        if1.b        = 16'h0001;
        if1.in_valid = 1'b1;
        step();
        if1.in_valid = 1'b0;
        repeat (7) step();
        check("abort.slice_valid", 32'(if1.slice_valid), 32'd1);
        check("abort.partial_out", 32'(if1.out),         32'h0035);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready",    32'(if1.in_ready),    32'd1);
        check("abort.out",         32'(if1.out),         32'd0);
        check("abort.slice_valid0", 32'(if1.slice_valid), 32'd0);
        check("abort.out_valid",   32'(if1.out_valid),   32'd0);
        step();
        rst_n = 1'b1;
        step();
        run1(16'hFFFF, 16'h0000, 16'hFFFF, "post");
        release1("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
